// File: rtl/boost_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// boost_frame_ctrl_if
// Signal bundle between the boost-filter frame controller and its neighbours:
// the command/config source, the pixel source, the datapath and the result
// sink.
//   slave  modport : controller side (boost_frame_ctrl)
//   master modport : environment side (command, source, datapath, sink)
// Signals:
//   start, cfg_width, cfg_height        frame command and geometry
//   src_valid / src_ready               source pixel handshake
//   dp_data_in                          pixel issue strobe to datapath
//   dp_wr_en, dp_result                 datapath retire strobe and result
//   out_valid, out_data, out_sol/eol/eof registered tagged result
//   busy, done, err_timeout, err_underflow  status
// ---------------------------------------------------------------------------
interface boost_frame_ctrl_if #(
    parameter int W_DIM = 12
);
    logic             start;
    logic [W_DIM-1:0] cfg_width;
    logic [W_DIM-1:0] cfg_height;
    logic             src_valid;
    logic             src_ready;
    logic             dp_data_in;
    logic             dp_wr_en;
    logic [7:0]       dp_result;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sol;
    logic             out_eol;
    logic             out_eof;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_underflow;

    modport slave (
        input  start, cfg_width, cfg_height, src_valid, dp_wr_en, dp_result,
        output src_ready, dp_data_in, out_valid, out_data, out_sol, out_eol,
               out_eof, busy, done, err_timeout, err_underflow
    );

    modport master (
        output start, cfg_width, cfg_height, src_valid, dp_wr_en, dp_result,
        input  src_ready, dp_data_in, out_valid, out_data, out_sol, out_eol,
               out_eof, busy, done, err_timeout, err_underflow
    );
endinterface

// File: rtl/boost_frame_ctrl.sv
// ---------------------------------------------------------------------------
// boost_frame_ctrl
// Frame-level sequencer for the boost-filter datapath. Accepts a start
// command with frame geometry, admits source pixels while the number of
// pixels in flight is below MAX_INFLIGHT, strobes them into the datapath,
// and tags every retired result with its raster position. Reports frame
// completion and traps datapath stalls and spurious retires.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : boost_frame_ctrl_if.slave (command, source, datapath, results,
//            status)
// ---------------------------------------------------------------------------
module boost_frame_ctrl #(
    parameter int W_DIM        = 12,
    parameter int MAX_INFLIGHT = 16,
    parameter int TIMEOUT      = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    boost_frame_ctrl_if.slave  bus
);
    localparam int CNT_W   = 2 * W_DIM;
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]         r_state;
    logic [W_DIM-1:0]   r_width;
    logic [W_DIM-1:0]   r_height;
    logic [CNT_W-1:0]   r_total;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_retired;
    logic [W_DIM-1:0]   r_col;
    logic [W_DIM-1:0]   r_row;
    logic [STALL_W-1:0] r_stall;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_sol;
    logic               r_out_eol;
    logic               r_out_eof;
    logic               r_done;
    logic               r_err_timeout;
    logic               r_err_underflow;

    logic             w_active;
    logic [CNT_W-1:0] w_inflight;
    logic             w_src_ready;
    logic             w_issue;
    logic             w_retire;
    logic             w_spurious;
    logic             w_start_ok;
    logic             w_last_issue;
    logic             w_last_retire;
    logic             w_stalled;
    logic             w_stall_hit;
    logic             w_col_last;

    assign w_active      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_inflight    = r_issued - r_retired;
    assign w_src_ready   = (r_state == S_RUN)
                         && (w_inflight < CNT_W'(MAX_INFLIGHT))
                         && (r_issued < r_total);
    assign w_issue       = bus.src_valid && w_src_ready;
    assign w_retire      = bus.dp_wr_en && w_active && (w_inflight != '0);
    // Any write strobe that is not a legal retire is dropped and flagged.
    assign w_spurious    = bus.dp_wr_en && !w_retire;
    assign w_start_ok    = bus.start && (r_state == S_IDLE);
    assign w_last_issue  = w_issue && ((r_issued + CNT_W'(1)) == r_total);
    assign w_last_retire = w_retire && ((r_retired + CNT_W'(1)) == r_total);
    assign w_stalled     = w_active && (w_inflight != '0) && !bus.dp_wr_en;
    // The TIMEOUT-th consecutive stalled cycle trips the error.
    assign w_stall_hit   = w_stalled && (r_stall == STALL_W'(TIMEOUT - 1));
    assign w_col_last    = (r_col == (r_width - W_DIM'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_width         <= '0;
            r_height        <= '0;
            r_total         <= '0;
            r_issued        <= '0;
            r_retired       <= '0;
            r_col           <= '0;
            r_row           <= '0;
            r_stall         <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_sol       <= 1'b0;
            r_out_eol       <= 1'b0;
            r_out_eof       <= 1'b0;
            r_done          <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_out_valid <= w_retire;
            // done is the registered image of FIN, so it lands one cycle
            // after the final result appears on out_valid.
            r_done      <= (r_state == S_FIN);

            if (w_issue) begin
                r_issued <= r_issued + CNT_W'(1);
            end

            if (w_retire) begin
                r_retired  <= r_retired + CNT_W'(1);
                r_out_data <= bus.dp_result;
                r_out_sol  <= (r_col == '0);
                r_out_eol  <= w_col_last;
                r_out_eof  <= w_col_last && (r_row == (r_height - W_DIM'(1)));
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + W_DIM'(1);
                end else begin
                    r_col <= r_col + W_DIM'(1);
                end
            end

            if (w_stalled) begin
                r_stall <= r_stall + STALL_W'(1);
            end else begin
                r_stall <= '0;
            end

            // Errors clear on an accepted start; a spurious strobe in that
            // same cycle still counts, so the set follows the clear.
            if (w_start_ok) begin
                r_err_timeout   <= 1'b0;
                r_err_underflow <= 1'b0;
            end
            if (w_stall_hit) begin
                r_err_timeout <= 1'b1;
            end
            if (w_spurious) begin
                r_err_underflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_width   <= bus.cfg_width;
                        r_height  <= bus.cfg_height;
                        r_total   <= CNT_W'(bus.cfg_width) * CNT_W'(bus.cfg_height);
                        r_issued  <= '0;
                        r_retired <= '0;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_stall   <= '0;
                        if ((bus.cfg_width == '0) || (bus.cfg_height == '0)) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_stall_hit) begin
                        r_state <= S_FIN;
                    end else if (w_last_issue) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_stall_hit || w_last_retire) begin
                        r_state <= S_FIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready     = w_src_ready;
    assign bus.dp_data_in    = w_issue;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_sol       = r_out_sol;
    assign bus.out_eol       = r_out_eol;
    assign bus.out_eof       = r_out_eof;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
    assign bus.err_timeout   = r_err_timeout;
    assign bus.err_underflow = r_err_underflow;
endmodule

// File: tb/tb_boost_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boost_frame_ctrl
// Randomized frames against a behavioural model of the frame controller:
// the bench plays the pixel source and a fixed-latency datapath, tracks
// issued/retired pixel counts, and predicts every tagged result from its
// index within the frame (col = k % width, eof = last k).
// ---------------------------------------------------------------------------
module tb_boost_frame_ctrl;
    localparam int W_DIM   = 12;
    localparam int MAX_INF = 16;
    localparam int TMO     = 4096;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    boost_frame_ctrl_if #(.W_DIM(W_DIM)) bus ();

    boost_frame_ctrl #(
        .W_DIM       (W_DIM),
        .MAX_INFLIGHT(MAX_INF),
        .TIMEOUT     (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One frame. Called just after a falling edge with the DUT idle.
    // stall_start/stall_len: window of cycles where the datapath holds retires.
    // stop_after: datapath never retires beyond this many results (-1 = no limit).
    task automatic run_frame(input int w, input int h, input int lat, input int vprob,
                             input int stall_start, input int stall_len, input int stop_after);
        int         total, issued, retired, outs, done_due, stall_cnt, k, cyc;
        bit         timed_out, exp_valid, exp_sol, exp_eol, exp_eof, can_ret, exp_ready, done_seen;
        bit         in_stall, vld;
        logic [7:0] exp_data, rdata;
        int         due_q[$];
        total     = w * h;
        issued    = 0;
        retired   = 0;
        outs      = 0;
        stall_cnt = 0;
        done_due  = (total == 0) ? 2 : -1;
        timed_out = 0;
        exp_valid = 0;
        exp_sol   = 0;
        exp_eol   = 0;
        exp_eof   = 0;
        exp_data  = '0;
        done_seen = 0;

        bus.start      = 1'b1;
        bus.cfg_width  = 12'(w);
        bus.cfg_height = 12'(h);
        bus.src_valid  = 1'b0;
        bus.dp_wr_en   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;

        for (cyc = 1; cyc < 6000; cyc++) begin
            check("out_valid", bus.out_valid, exp_valid);
            if (exp_valid) begin
                check("out_data", bus.out_data, exp_data);
                check("out_sol", bus.out_sol, exp_sol);
                check("out_eol", bus.out_eol, exp_eol);
                check("out_eof", bus.out_eof, exp_eof);
            end
            if (bus.out_valid) outs++;
            check("done", bus.done, cyc == done_due);
            check("busy", bus.busy, (done_due < 0) || (cyc < done_due));
            check("err_timeout", bus.err_timeout, timed_out);
            check("err_underflow", bus.err_underflow, 1'b0);
            if (cyc == done_due) begin
                done_seen = 1;
                break;
            end

            vld = ($urandom_range(99) < vprob);
            in_stall = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            can_ret = !timed_out && (due_q.size() > 0) && !in_stall
                      && ((stop_after < 0) || (retired < stop_after));
            if (can_ret) can_ret = (due_q[0] <= cyc);
            rdata = 8'($urandom);
            bus.src_valid = vld;
            bus.dp_wr_en  = can_ret;
            bus.dp_result = rdata;
            #1;
            exp_ready = !timed_out && (issued < total) && ((issued - retired) < MAX_INF);
            check("src_ready", bus.src_ready, exp_ready);
            check("dp_data_in", bus.dp_data_in, vld && exp_ready);

            if (((issued - retired) > 0) && !can_ret) stall_cnt++;
            else stall_cnt = 0;
            if (!timed_out && stall_cnt == TMO) begin
                timed_out = 1;
                done_due  = cyc + 2;
            end

            if (vld && exp_ready) begin
                issued++;
                due_q.push_back(cyc + lat);
            end
            exp_valid = can_ret;
            if (can_ret) begin
                k        = due_q.pop_front();
                k        = retired;
                exp_data = rdata;
                exp_sol  = (k % w) == 0;
                exp_eol  = (k % w) == (w - 1);
                exp_eof  = (k == total - 1);
                retired++;
                if (retired == total) done_due = cyc + 2;
            end
            @(negedge clk);
        end
        bus.src_valid = 1'b0;
        bus.dp_wr_en  = 1'b0;
        check("frame_end", done_seen, 1'b1);
        check("out_count", outs, retired);
        if (stop_after < 0) check("retired_all", retired, total);
        $display("frame w=%0d h=%0d lat=%0d issued=%0d results=%0d timeout=%0d",
                 w, h, lat, issued, outs, timed_out);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_data"}, bus.out_data, 8'h00);
        check({tag, "_flags"}, {bus.out_sol, bus.out_eol, bus.out_eof}, 3'b000);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_src_ready"}, bus.src_ready, 1'b0);
        check({tag, "_dp_data_in"}, bus.dp_data_in, 1'b0);
        check({tag, "_errs"}, {bus.err_timeout, bus.err_underflow}, 2'b00);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.cfg_width  = '0;
        bus.cfg_height = '0;
        bus.src_valid  = 1'b0;
        bus.dp_wr_en   = 1'b0;
        bus.dp_result  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(4, 2, 5, 100, 0, 0, -1);   // basic raster tagging
        run_frame(8, 8, 5, 100, 1, 40, -1);  // credit cap during retire stall
        run_frame(8, 8, 5, 100, 0, 0, -1);   // steady issue+retire at inflight 5
        run_frame(0, 3, 5, 100, 0, 0, -1);   // zero width
        run_frame(5, 0, 5, 100, 0, 0, -1);   // zero height
        run_frame(1, 5, 3, 70, 0, 0, -1);    // single column: sol and eol together
        run_frame(3, 1, 5, 100, 0, 0, 0);    // datapath never retires -> timeout
        run_frame(2, 2, 2, 100, 0, 0, -1);   // next start clears err_timeout

        // Spurious retire while idle.
        bus.dp_wr_en  = 1'b1;
        bus.dp_result = 8'hA5;
        @(negedge clk);
        bus.dp_wr_en = 1'b0;
        check("spurious_underflow", bus.err_underflow, 1'b1);
        check("spurious_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("underflow_sticky", bus.err_underflow, 1'b1);
        check("spurious_out_valid2", bus.out_valid, 1'b0);
        run_frame(3, 3, 4, 80, 0, 0, -1);    // start clears err_underflow

        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(9, 1), $urandom_range(6, 1), $urandom_range(20, 1),
                      $urandom_range(100, 30), $urandom_range(30, 1), $urandom_range(60, 0), -1);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        // Reset in the middle of a frame.
        bus.start      = 1'b1;
        bus.cfg_width  = 12'd6;
        bus.cfg_height = 12'd6;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.src_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("midframe_busy", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n         = 1'b1;
        bus.src_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_done", bus.done, 1'b0);
            check("abort_busy", bus.busy, 1'b0);
            check("abort_out_valid", bus.out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
